control_contador: RTL and testbench

//  Synthesizable command sequencer that drives the counter interface (ENB, MODO, D) and

---
 rtl/control_contador_pkg.sv | 12 +
 rtl/control_contador_if.sv | 27 ++
 rtl/control_contador_rco_acumulador.sv | 19 +
 rtl/control_contador.sv | 102 ++++++++++
 tb/tb_control_contador.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/control_contador_pkg.sv
// control_contador_pkg: shared FSM state encoding and counter MODO constants for the contador sequencer
package ctrl_contador_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SETTLE = 2'd2
  } state_t;
  localparam logic [1:0] MODO_UP    = 2'b00;
  localparam logic [1:0] MODO_DOWN1 = 2'b01;
  localparam logic [1:0] MODO_DOWN3 = 2'b10;
  localparam logic [1:0] MODO_LOAD  = 2'b11;
endpackage

// File: rtl/control_contador_if.sv
// control_contador_if: command handshake plus counter-facing signals of the contador sequencer
interface control_contador_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             CMD_VALID;
  logic             CMD_READY;
  logic [1:0]       CMD_OP;
  logic [WIDTH-1:0] CMD_DATA;
  logic [CNT_W-1:0] CMD_STEPS;
  logic             ENB;
  logic [1:0]       MODO;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             RCO;
  logic             DONE;
  logic [CNT_W-1:0] RCO_CNT;
  logic [WIDTH-1:0] LAST_Q;
  modport slave (
    input  CMD_VALID, CMD_OP, CMD_DATA, CMD_STEPS, Q, RCO,
    output CMD_READY, ENB, MODO, D, DONE, RCO_CNT, LAST_Q
  );
  modport master (
    output CMD_VALID, CMD_OP, CMD_DATA, CMD_STEPS, Q, RCO,
    input  CMD_READY, ENB, MODO, D, DONE, RCO_CNT, LAST_Q
  );
endinterface

// File: rtl/control_contador_rco_acumulador.sv
// rco_acumulador: saturating pulse counter with synchronous clear
module rco_acumulador #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // clear wins over increment; count sticks at all-ones
  always_comb cnt_d = clr ? '0 : (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  // count register
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/control_contador.sv
// control_contador: command sequencer driving a contador counter (ENB/MODO/D), tallying RCO and capturing Q; define CTRL_RCO_STOP_EN to let RCO end a burst early
module control_contador
  import ctrl_contador_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic CLK,
  input  logic RESET,
  control_contador_if.slave bus
);
  state_t state_q, state_d;
  logic ready_q, ready_d, enb_q, enb_d, done_q, done_d;
  logic clr, inc, stop;
  logic [1:0] modo_q, modo_d;
  logic [WIDTH-1:0] d_q, d_d, last_q_q, last_q_d;
  logic [CNT_W-1:0] rem_q, rem_d, rco_cnt;
`ifdef CTRL_RCO_STOP_EN
  assign stop = bus.RCO;
`else
  assign stop = 1'b0;
`endif
  // next-state: accept in IDLE, burn down the step budget in RUN, report in SETTLE
  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    enb_d    = enb_q;
    modo_d   = modo_q;
    d_d      = d_q;
    done_d   = 1'b0;
    last_q_d = last_q_q;
    rem_d    = rem_q;
    clr      = 1'b0;
    inc      = 1'b0;
    case (state_q)
      IDLE: if (bus.CMD_VALID && ready_q) begin
        modo_d  = bus.CMD_OP;
        d_d     = bus.CMD_DATA;
        enb_d   = 1'b1;
        rem_d   = (bus.CMD_STEPS == '0) ? CNT_W'(1) : bus.CMD_STEPS;
        clr     = 1'b1;
        ready_d = 1'b0;
        state_d = RUN;
      end
      RUN: begin
        rem_d = rem_q - 1'b1;
        inc   = bus.RCO;
        if (rem_q == CNT_W'(1) || stop) begin
          enb_d   = 1'b0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        last_q_d = bus.Q;
        done_d   = 1'b1;
        inc      = bus.RCO;
        ready_d  = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        enb_d   = 1'b0;
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end
  // all sequencer state and registered outputs
  always_ff @(posedge CLK)
    if (RESET) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      enb_q    <= 1'b0;
      modo_q   <= MODO_UP;
      d_q      <= '0;
      done_q   <= 1'b0;
      last_q_q <= '0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      enb_q    <= enb_d;
      modo_q   <= modo_d;
      d_q      <= d_d;
      done_q   <= done_d;
      last_q_q <= last_q_d;
      rem_q    <= rem_d;
    end
  rco_acumulador #(.CNT_W(CNT_W)) u_rco (
    .clk(CLK),
    .rst(RESET),
    .clr(clr),
    .inc(inc),
    .cnt(rco_cnt)
  );
  assign bus.CMD_READY = ready_q;
  assign bus.ENB       = enb_q;
  assign bus.MODO      = modo_q;
  assign bus.D         = d_q;
  assign bus.DONE      = done_q;
  assign bus.RCO_CNT   = rco_cnt;
  assign bus.LAST_Q    = last_q_q;
endmodule

// File: tb/tb_control_contador.sv
// tb_control_contador: drives control_contador against behavioural 4-bit and 16-bit counters and checks it against a command-level model
module tb_control_contador;
  typedef struct packed {
    logic [3:0] lastq;
    logic [7:0] rco;
    int         len;
  } exp_t;

  logic clk, rst;
  int total, bad;
  exp_t expq[$];
  logic [3:0] mq, q4, cur_data;
  logic [1:0] cur_op;
  logic [15:0] q16;
  logic rco4, rco16;
  int len4, last_len;

  control_contador_if #(.WIDTH(4), .CNT_W(8)) b4();
  control_contador_if #(.WIDTH(16), .CNT_W(8)) b16();

  control_contador #(.WIDTH(4), .CNT_W(8)) u4 (.CLK(clk), .RESET(rst), .bus(b4));
  control_contador #(.WIDTH(16), .CNT_W(8)) u16 (.CLK(clk), .RESET(rst), .bus(b16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural counters: RCO is high while enabled and the next step wraps
  assign rco4 = b4.ENB && ((b4.MODO == 2'b00 && q4 == 4'hF) || (b4.MODO == 2'b01 && q4 == 4'h0) ||
                           (b4.MODO == 2'b10 && q4 < 4'd3));
  assign rco16 = b16.ENB && ((b16.MODO == 2'b00 && q16 == 16'hFFFF) || (b16.MODO == 2'b01 && q16 == 16'h0) ||
                             (b16.MODO == 2'b10 && q16 < 16'd3));
  assign b4.Q = q4;
  assign b4.RCO = rco4;
  assign b16.Q = q16;
  assign b16.RCO = rco16;
  always_ff @(posedge clk)
    if (rst) q4 <= '0;
    else if (b4.ENB) q4 <= (b4.MODO == 2'b00) ? q4 + 4'd1 : (b4.MODO == 2'b01) ? q4 - 4'd1 :
                           (b4.MODO == 2'b10) ? q4 - 4'd3 : b4.D;
  always_ff @(posedge clk)
    if (rst) q16 <= '0;
    else if (b16.ENB) q16 <= (b16.MODO == 2'b00) ? q16 + 16'd1 : (b16.MODO == 2'b01) ? q16 - 16'd1 :
                             (b16.MODO == 2'b10) ? q16 - 16'd3 : b16.D;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, want, $time);
    end
  endtask

  // command-level model: walk the counter arithmetic STEPS times and tally wraps
  function automatic exp_t model4(input logic [1:0] op, input logic [3:0] data, input logic [7:0] steps,
                                  input logic [3:0] q0);
    exp_t e;
    int n, r;
    logic [3:0] q;
    q = q0;
    r = 0;
    n = (steps == 8'd0) ? 1 : int'(steps);
    for (int i = 0; i < n; i++) begin
      if (op == 2'b00) begin if (q == 4'hF) r++; q = q + 4'd1; end
      else if (op == 2'b01) begin if (q == 4'h0) r++; q = q - 4'd1; end
      else if (op == 2'b10) begin if (q < 4'd3) r++; q = q - 4'd3; end
      else q = data;
    end
    e.lastq = q;
    e.rco = (r > 255) ? 8'd255 : 8'(r);
    e.len = n;
    return e;
  endfunction

  // per-cycle comparison of the 4-bit sequencer against the model
  initial forever begin
    @(negedge clk);
    if (rst) len4 = 0;
    else begin
      if (b4.ENB) len4++;
      if (!b4.CMD_READY) begin
        chk("modo_hold", {30'd0, b4.MODO}, {30'd0, cur_op});
        chk("d_hold", {28'd0, b4.D}, {28'd0, cur_data});
      end else chk("enb_idle", {31'd0, b4.ENB}, 32'd0);
      if (b4.DONE) begin
        if (expq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = expq.pop_front();
          chk("last_q", {28'd0, b4.LAST_Q}, {28'd0, e.lastq});
          chk("rco_cnt", {24'd0, b4.RCO_CNT}, {24'd0, e.rco});
          chk("enb_len", len4, e.len);
        end
        last_len = len4;
        len4 = 0;
      end
    end
  end

  task automatic offer4(input logic [1:0] op, input logic [3:0] data, input logic [7:0] steps, input int hold);
    int n;
    @(negedge clk);
    b4.CMD_VALID = 1'b1;
    b4.CMD_OP = op;
    b4.CMD_DATA = data;
    b4.CMD_STEPS = steps;
    n = 0;
    while (!b4.CMD_READY && n < 50) begin @(negedge clk); n++; end
    if (!b4.CMD_READY) chk("ready_timeout", 32'd0, 32'd1);
    cur_op = op;
    cur_data = data;
    @(posedge clk);
    for (int i = 0; i < hold; i++) @(posedge clk);
    #1 b4.CMD_VALID = 1'b0;
  endtask

  task automatic cmd4(input logic [1:0] op, input logic [3:0] data, input logic [7:0] steps, input int hold);
    int n;
    exp_t e;
    e = model4(op, data, steps, mq);
    mq = e.lastq;
    expq.push_back(e);
    offer4(op, data, steps, hold);
    n = 0;
    do begin @(negedge clk); n++; end while (!b4.DONE && n < 600);
    if (!b4.DONE) chk("done_timeout", 32'd0, 32'd1);
    #1;
  endtask

  task automatic cmd16(input logic [1:0] op, input logic [15:0] data, input logic [7:0] steps,
                       output logic [15:0] lq, output logic [7:0] rc, output int len);
    int n;
    @(negedge clk);
    b16.CMD_VALID = 1'b1;
    b16.CMD_OP = op;
    b16.CMD_DATA = data;
    b16.CMD_STEPS = steps;
    n = 0;
    while (!b16.CMD_READY && n < 50) begin @(negedge clk); n++; end
    if (!b16.CMD_READY) chk("ready16_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 b16.CMD_VALID = 1'b0;
    len = 0;
    n = 0;
    do begin
      @(negedge clk);
      if (b16.ENB) len++;
      n++;
    end while (!b16.DONE && n < 600);
    if (!b16.DONE) chk("done16_timeout", 32'd0, 32'd1);
    lq = b16.LAST_Q;
    rc = b16.RCO_CNT;
  endtask

  initial begin
    logic [15:0] lq16;
    logic [7:0] rc16;
    int l16;
    total = 0;
    bad = 0;
    len4 = 0;
    last_len = 0;
    mq = 4'h0;
    cur_op = 2'b00;
    cur_data = 4'h0;
    rst = 1'b1;
    {b4.CMD_VALID, b4.CMD_OP, b4.CMD_DATA, b4.CMD_STEPS} = '0;
    {b16.CMD_VALID, b16.CMD_OP, b16.CMD_DATA, b16.CMD_STEPS} = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, b4.CMD_READY}, 32'd1);
    chk("rst_last_q", {28'd0, b4.LAST_Q}, 32'd0);
    rst = 1'b0;
    // load then count up
    cmd4(2'b11, 4'hA, 8'd1, 0);
    chk("lit_load_a", {28'd0, b4.LAST_Q}, 32'hA);
    cmd4(2'b00, 4'h0, 8'd3, 0);
    chk("lit_up3_d", {28'd0, b4.LAST_Q}, 32'hD);
    // wrap upward through F->0
    cmd4(2'b11, 4'hE, 8'd1, 0);
    cmd4(2'b00, 4'h0, 8'd4, 0);
    chk("lit_wrap_q", {28'd0, b4.LAST_Q}, 32'h2);
    chk("lit_wrap_rco", {24'd0, b4.RCO_CNT}, 32'd1);
    chk("lit_wrap_len", last_len, 4);
    // reset held 3 cycles in the middle of a burst
    offer4(2'b00, 4'h0, 8'd8, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_enb", {31'd0, b4.ENB}, 32'd0);
      chk("rst_modo", {30'd0, b4.MODO}, 32'd0);
      chk("rst_ready_mid", {31'd0, b4.CMD_READY}, 32'd1);
      chk("rst_done", {31'd0, b4.DONE}, 32'd0);
      chk("rst_rco_cnt", {24'd0, b4.RCO_CNT}, 32'd0);
    end
    rst = 1'b0;
    mq = 4'h0;
    repeat (4) @(negedge clk);
    chk("post_rst_done", {31'd0, b4.DONE}, 32'd0);
    // underflow with the step-by-3 mode
    cmd4(2'b11, 4'h2, 8'd1, 0);
    cmd4(2'b10, 4'h0, 8'd2, 0);
    chk("lit_down3_q", {28'd0, b4.LAST_Q}, 32'hC);
    chk("lit_down3_rco", {24'd0, b4.RCO_CNT}, 32'd1);
    cmd4(2'b01, 4'h0, 8'd3, 0);
    cmd4(2'b11, 4'h5, 8'd3, 0);
    // zero steps means one, with CMD_VALID held while busy
    cmd4(2'b00, 4'h0, 8'd0, 2);
    chk("lit_steps0_len", last_len, 1);
    chk("lit_steps0_q", {28'd0, b4.LAST_Q}, 32'h6);
    cmd4(2'b00, 4'h0, 8'd20, 0);
    repeat (6) @(negedge clk);
    chk("pending_cmds", expq.size(), 0);
    // 16-bit counter: load near the top and count up past the wrap
    cmd16(2'b11, 16'hFFFE, 8'd1, lq16, rc16, l16);
    chk("lit16_load", {16'd0, lq16}, 32'hFFFE);
    cmd16(2'b00, 16'h0, 8'd10, lq16, rc16, l16);
    chk("lit16_rco", {24'd0, rc16}, 32'd1);
`ifdef CTRL_RCO_STOP_EN
    chk("lit16_len", l16, 2);
    chk("lit16_q", {16'd0, lq16}, 32'h0000);
`else
    chk("lit16_len", l16, 10);
    chk("lit16_q", {16'd0, lq16}, 32'h0008);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
